// File: rtl/conv_8x32_pkg.sv
// Shared constants, state encoding and tap-range helpers for the 1-D
// convolution sequencer. The optional stall counter of the top level is
// enabled by defining CONV_SEQ_STALL_CNT_EN.
package conv_8x32_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int SIG_LEN    = 32;
    localparam int KER_LEN    = 8;

    localparam int NUM_OUT    = SIG_LEN + KER_LEN - 1;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(KER_LEN);
    localparam int XA_WIDTH   = $clog2(SIG_LEN);
    localparam int HA_WIDTH   = $clog2(KER_LEN);
    localparam int IDX_WIDTH  = $clog2(NUM_OUT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // First kernel tap that touches the signal for output n.
    function automatic logic [HA_WIDTH-1:0] kmin_of(input logic [IDX_WIDTH-1:0] n);
        if (int'(n) > SIG_LEN - 1)
            return HA_WIDTH'(int'(n) - (SIG_LEN - 1));
        else
            return '0;
    endfunction

    // Last kernel tap that touches the signal for output n.
    function automatic logic [HA_WIDTH-1:0] kmax_of(input logic [IDX_WIDTH-1:0] n);
        if (int'(n) < KER_LEN - 1)
            return HA_WIDTH'(n);
        else
            return HA_WIDTH'(KER_LEN - 1);
    endfunction

endpackage

// File: rtl/conv_8x32_tap_gen.sv
// Tap walker: holds the current kernel index k for output n, derives the
// matching signal address n-k and flags the last in-range tap.
module conv_8x32_tap_gen
    import conv_8x32_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [IDX_WIDTH-1:0] n_load,
    input  logic                 advance,
    input  logic [IDX_WIDTH-1:0] n,
    output logic [HA_WIDTH-1:0]  k,
    output logic [XA_WIDTH-1:0]  x_addr,
    output logic                 last_tap
);

    logic [HA_WIDTH-1:0] k_reg;

    // k starts at the first valid tap of the next output and steps upward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg <= '0;
        end else if (load) begin
            k_reg <= kmin_of(n_load);
        end else if (advance) begin
            k_reg <= k_reg + 1'b1;
        end
    end

    assign k        = k_reg;
    // n-k is always within the signal while k lies in [kmin, kmax].
    assign x_addr   = XA_WIDTH'(n - IDX_WIDTH'(k_reg));
    assign last_tap = (k_reg == kmax_of(n));

endmodule

// File: rtl/conv_8x32_seq_ctrl.sv
// Convolution sequencer: walks every output n, issues buffer reads for the
// in-range taps, accumulates the shared multiplier's products and streams
// y[n] over valid/ready. Optional backpressure counter: CONV_SEQ_STALL_CNT_EN.
module conv_8x32_seq_ctrl
    import conv_8x32_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [XA_WIDTH-1:0]     x_addr_o,
    output logic [HA_WIDTH-1:0]     h_addr_o,
    output logic                    rd_en_o,
    input  logic [DATA_WIDTH-1:0]   x_data_i,
    input  logic [DATA_WIDTH-1:0]   h_data_i,
    output logic [DATA_WIDTH-1:0]   mult_a_o,
    output logic [DATA_WIDTH-1:0]   mult_b_o,
    input  logic [2*DATA_WIDTH-1:0] mult_d_i,
    output logic [ACC_WIDTH-1:0]    y_data_o,
    output logic [IDX_WIDTH-1:0]    y_idx_o,
    output logic                    y_valid_o,
    input  logic                    y_ready_i,
    output logic [15:0]             stall_cnt_o
);

    state_t                 state_reg, state_next;
    logic [IDX_WIDTH-1:0]   n_reg;
    logic [ACC_WIDTH-1:0]   acc_reg;
    logic                   acc_en_reg;

    logic                   start_ok;
    logic                   handshake;
    logic                   last_out;
    logic                   tap_load;
    logic [IDX_WIDTH-1:0]   tap_n_load;
    logic                   tap_adv;
    logic                   rd_en;
    logic                   y_valid;
    logic [HA_WIDTH-1:0]    k;
    logic [XA_WIDTH-1:0]    x_addr;
    logic                   last_tap;

    assign start_ok  = (state_reg == IDLE) && start_i;
    assign handshake = (state_reg == OUT) && y_ready_i;
    assign last_out  = (n_reg == IDX_WIDTH'(NUM_OUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next = state_reg;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        rd_en      = 1'b0;
        y_valid    = 1'b0;
        tap_load   = 1'b0;
        tap_n_load = '0;
        tap_adv    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = RUN;
                    tap_load   = 1'b1;
                    tap_n_load = '0;
                end
            end
            RUN: begin
                busy_o  = 1'b1;
                rd_en   = 1'b1;
                tap_adv = !last_tap;
                if (last_tap) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy_o     = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                busy_o  = 1'b1;
                y_valid = 1'b1;
                if (y_ready_i) begin
                    if (last_out) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        tap_load   = 1'b1;
                        tap_n_load = n_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                busy_o     = 1'b1;
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output index: restarts on an accepted start, advances per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg <= '0;
        end else if (start_ok) begin
            n_reg <= '0;
        end else if (handshake && !last_out) begin
            n_reg <= n_reg + 1'b1;
        end
    end

    // Read data arrives one cycle after the strobe, so accumulate one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_en_reg <= 1'b0;
        end else begin
            acc_en_reg <= rd_en;
        end
    end

    // Accumulator: cleared on every RUN entry, summed while products arrive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (tap_load) begin
            acc_reg <= '0;
        end else if (acc_en_reg) begin
            acc_reg <= acc_reg + ACC_WIDTH'(mult_d_i);
        end
    end

    conv_8x32_tap_gen u_tap_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tap_load),
        .n_load   (tap_n_load),
        .advance  (tap_adv),
        .n        (n_reg),
        .k        (k),
        .x_addr   (x_addr),
        .last_tap (last_tap)
    );

    assign rd_en_o   = rd_en;
    assign x_addr_o  = rd_en ? x_addr : '0;
    assign h_addr_o  = rd_en ? k : '0;
    assign mult_a_o  = x_data_i;
    assign mult_b_o  = h_data_i;
    assign y_valid_o = y_valid;
    assign y_data_o  = y_valid ? acc_reg : '0;
    assign y_idx_o   = n_reg;

`ifdef CONV_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Saturating count of OUT cycles refused by the downstream side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (start_ok) begin
            stall_cnt_reg <= '0;
        end else if (y_valid && !y_ready_i && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
